lcd_char_feeder: RTL
====================

// Module: lcd_char_feeder
// PURPOSE
//  Upstream command source for the character-LCD controller. Buffers ASCII characters
//  from a producer (valid/ready) and turns them into single transactions on the
//  controller's lcd_enable/lcd_bus/busy interface. Each transaction is a data write,
//  a DDRAM-address command or a clear command. Tracks the cursor, so text wraps
//  across a COLS x ROWS display.
// PARAMETERS
//  COLS        16  visible columns per row (2..40)
//  ROWS         2  display rows (1 or 2); row 1 DDRAM base = 0x40
//  FIFO_DEPTH   4  character buffer entries (power of 2)
//  ACK_TIMEOUT 15  cycles to wait for lcd_busy high after an enable pulse before retry
// PORTS
//  clk          in   1   rising-edge clock, shared with the LCD controller
//  rst_n        in   1   synchronous reset, active low
//  char_data    in   8   ASCII character; 0x0A = newline
//  char_valid   in   1   producer has char_data
//  char_ready   out  1   FIFO not full; char accepted when char_valid && char_ready
//  clear_req    in   1   one-cycle pulse: clear display and home cursor
//  lcd_busy     in   1   controller busy (registered in controller)
//  lcd_enable   out  1   one-cycle transaction strobe to controller
//  lcd_bus      out  10  {rs, rw, data[7:0]} to controller; stable from strobe until done
//  cursor_col   out  $clog2(COLS)  current column
//  cursor_row   out  1   current row
//  retry_pulse  out  1   one-cycle pulse when ACK_TIMEOUT expires and the transaction is re-issued
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - lcd_enable=0, lcd_bus=0, retry_pulse=0, cursor=(0,0), FIFO empty.
//   - clear/wrap pending flags=0, state=IDLE, char_ready=0 while in reset.
//   - Reset mid-transaction abandons it; no enable is re-issued.
//  char_ready = !fifo_full (registered-state derived). Push on valid&&ready.
//  clear_req sets sticky clear_pend; further pulses while pending merge into one.
//  FSM states: IDLE -> ISSUE -> WAIT_ACK -> WAIT_DONE -> IDLE.
//  IDLE: if lcd_busy==0, dispatch by priority into a hold register, then go to ISSUE:
//   1. clear_pend: bus = {2'b00, 8'h01}.
//   2. addr_pend:  bus = {2'b00, 1'b1, addr[6:0]}, addr = row ? 0x40 : 0x00 (col 0).
//   3. FIFO non-empty, pop head:
//      - 0x0A: no write. col=0, row=(row+1)%ROWS, set addr_pend.
//        Stays IDLE; the address command goes next dispatch.
//      - other: bus = {2'b10, ch}.
//   Otherwise remain IDLE.
//  ISSUE: lcd_enable=1 for exactly one cycle, lcd_bus=hold, then WAIT_ACK.
//  WAIT_ACK: on lcd_busy==1 go to WAIT_DONE. If ACK_TIMEOUT cycles pass without it,
//   pulse retry_pulse and return to ISSUE with the same hold value.
//  WAIT_DONE: on lcd_busy==0 the transaction completes, then IDLE; effects apply on
//   that cycle:
//   - clear: cursor=(0,0), clear_pend=0, addr_pend=0.
//   - addr:  addr_pend=0.
//   - char:  col+1. At col==COLS-1: col=0, row=(row+1)%ROWS, set addr_pend.
//  lcd_enable is never asserted outside ISSUE; at most one transaction in flight.
//  clear_req arriving mid-transaction waits; the in-flight char still completes and
//   advances the cursor, then the clear resets it.
//  Simultaneous push and pop on a full FIFO: push is refused (char_ready=0 that cycle).
//  Pointers wrap modulo FIFO_DEPTH, using a count of width $clog2(FIFO_DEPTH)+1.
// STRUCTURE
//  Shared package lcd_pkg: state enum, LCD_CMD_CLEAR=8'h01, LCD_CMD_DDRAM=8'h80,
//  LCD_ROW1_BASE=7'h40, LCD_CHAR_NL=8'h0A, and the rs/rw bit positions in lcd_bus.
//  One sub-module: lcd_char_fifo (sync FIFO: push/pop/full/empty/head).
//  FSM, cursor and pending flags stay in lcd_char_feeder.
// TESTING (bench includes a controller model with 1-cycle busy latency, 20-cycle ops)
//  1. Reset, push "AB" -> two enables; lcd_bus=0x241, then 0x242; cursor_col ends at 2.
//  2. Push 17 chars with COLS=16 -> 16 writes; then addr cmd lcd_bus=0x0C0; then
//     17th write; cursor=(1,1).
//  3. Push 'X', 0x0A, 'Y' from (0,0) -> writes 0x258, addr 0x0C0, write 0x259;
//     no data write for 0x0A.
//  4. clear_req during the 3rd char's WAIT_DONE -> that char completes; next enable
//     lcd_bus=0x001; cursor=(0,0); a second clear_req pulse meanwhile yields no extra clear.
//  5. Model ignores first enable -> retry_pulse after 15 cycles; same lcd_bus re-strobed;
//     exactly one write completes.
//  6. Hold char_valid=1 with stalled model -> char_ready drops after 4 accepts;
//     rst_n=0 mid-WAIT_DONE -> all outputs 0 next cycle, FIFO empty.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and LCD command encodings for the character feeder and its FIFO.
// lcd_bus layout is {rs, rw, data[7:0]}.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } feeder_state_e;

    typedef enum logic [1:0] {
        TXN_CHAR  = 2'd0,
        TXN_ADDR  = 2'd1,
        TXN_CLEAR = 2'd2
    } txn_kind_e;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_DDRAM = 8'h80;
    localparam logic [6:0] LCD_ROW1_BASE = 7'h40;
    localparam logic [7:0] LCD_CHAR_NL   = 8'h0A;

    localparam int LCD_BUS_W  = 10;
    localparam int LCD_BUS_RS = 9;
    localparam int LCD_BUS_RW = 8;

    function automatic logic [LCD_BUS_W-1:0] lcd_word(
        input logic       rs,
        input logic       rw,
        input logic [7:0] data
    );
        logic [LCD_BUS_W-1:0] w;
        w             = {2'b00, data};
        w[LCD_BUS_RS] = rs;
        w[LCD_BUS_RW] = rw;
        return w;
    endfunction

endpackage

// File: rtl/lcd_char_fifo.sv
// Small synchronous FIFO for buffered characters; a push while full is dropped,
// so the producer must honour the full flag.
module lcd_char_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the empty count masks stale entries.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/lcd_char_feeder.sv
// Turns a buffered ASCII stream into single LCD controller transactions
// (data write, DDRAM address, clear) while tracking the cursor for text wrap.
//
//  state        | meaning
//  -------------+----------------------------------------------------------
//  ST_IDLE      | controller idle check; pick clear > address > next char
//  ST_ISSUE     | one-cycle lcd_enable strobe with the held bus word
//  ST_WAIT_ACK  | wait for lcd_busy to rise; re-issue after ACK_TIMEOUT
//  ST_WAIT_DONE | wait for lcd_busy to fall, then apply the transaction
module lcd_char_feeder
    import lcd_pkg::*;
#(
    parameter int COLS        = 16,
    parameter int ROWS        = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              char_data,
    input  logic                    char_valid,
    output logic                    char_ready,
    input  logic                    clear_req,
    input  logic                    lcd_busy,
    output logic                    lcd_enable,
    output logic [LCD_BUS_W-1:0]    lcd_bus,
    output logic [$clog2(COLS)-1:0] cursor_col,
    output logic                    cursor_row,
    output logic                    retry_pulse
);

    localparam int COL_W = $clog2(COLS);
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    feeder_state_e        state_q, state_d;
    txn_kind_e            hold_kind_q, hold_kind_d;
    logic [LCD_BUS_W-1:0] hold_bus_q, hold_bus_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic                 row_q, row_d;
    logic                 clear_pend_q, clear_pend_d;
    logic                 addr_pend_q, addr_pend_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic                 retry_q, retry_d;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [7:0]           fifo_head;
    logic [7:0]           ddram_cmd;

    function automatic logic next_row(input logic r);
        return (ROWS == 2) ? ~r : 1'b0;
    endfunction

    assign char_ready = rst_n && !fifo_full;
    assign fifo_push  = char_valid && char_ready;
    assign ddram_cmd  = LCD_CMD_DDRAM | {1'b0, (row_q ? LCD_ROW1_BASE : 7'h00)};

    lcd_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (char_data),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_comb begin
        state_d      = state_q;
        hold_kind_d  = hold_kind_q;
        hold_bus_d   = hold_bus_q;
        col_d        = col_q;
        row_d        = row_q;
        clear_pend_d = clear_pend_q | clear_req;
        addr_pend_d  = addr_pend_q;
        timer_d      = timer_q;
        retry_d      = 1'b0;
        fifo_pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!lcd_busy) begin
                    if (clear_pend_q) begin
                        hold_bus_d  = lcd_word(1'b0, 1'b0, LCD_CMD_CLEAR);
                        hold_kind_d = TXN_CLEAR;
                        state_d     = ST_ISSUE;
                    end else if (addr_pend_q) begin
                        hold_bus_d  = lcd_word(1'b0, 1'b0, ddram_cmd);
                        hold_kind_d = TXN_ADDR;
                        state_d     = ST_ISSUE;
                    end else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        // Newline only moves the cursor; the address command follows.
                        if (fifo_head == LCD_CHAR_NL) begin
                            col_d       = '0;
                            row_d       = next_row(row_q);
                            addr_pend_d = 1'b1;
                        end else begin
                            hold_bus_d  = lcd_word(1'b1, 1'b0, fifo_head);
                            hold_kind_d = TXN_CHAR;
                            state_d     = ST_ISSUE;
                        end
                    end
                end
            end

            ST_ISSUE: begin
                timer_d = TMR_W'(ACK_TIMEOUT - 1);
                state_d = ST_WAIT_ACK;
            end

            ST_WAIT_ACK: begin
                if (lcd_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (timer_q == '0) begin
                    retry_d = 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end

            ST_WAIT_DONE: begin
                if (!lcd_busy) begin
                    state_d = ST_IDLE;
                    case (hold_kind_q)
                        TXN_CLEAR: begin
                            col_d        = '0;
                            row_d        = 1'b0;
                            addr_pend_d  = 1'b0;
                            // A request landing on the completion cycle is kept.
                            clear_pend_d = clear_req;
                        end
                        TXN_ADDR: begin
                            addr_pend_d = 1'b0;
                        end
                        default: begin
                            if (col_q == COL_W'(COLS - 1)) begin
                                col_d       = '0;
                                row_d       = next_row(row_q);
                                addr_pend_d = 1'b1;
                            end else begin
                                col_d = col_q + COL_W'(1);
                            end
                        end
                    endcase
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            hold_kind_q  <= TXN_CHAR;
            hold_bus_q   <= '0;
            col_q        <= '0;
            row_q        <= 1'b0;
            clear_pend_q <= 1'b0;
            addr_pend_q  <= 1'b0;
            timer_q      <= '0;
            retry_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_kind_q  <= hold_kind_d;
            hold_bus_q   <= hold_bus_d;
            col_q        <= col_d;
            row_q        <= row_d;
            clear_pend_q <= clear_pend_d;
            addr_pend_q  <= addr_pend_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
        end
    end

    assign lcd_enable  = (state_q == ST_ISSUE);
    assign lcd_bus     = hold_bus_q;
    assign cursor_col  = col_q;
    assign cursor_row  = row_q;
    assign retry_pulse = retry_q;

endmodule
